img_pool_downsample: RTL and testbench

IMG_POOL_DOWNSAMPLE -- requirements
Module: img_pool_downsample

---
 rtl/img_pool_pkg.sv | 15 +
 rtl/pool_accum_ram.sv | 27 ++
 rtl/img_pool_downsample.sv | 202 ++++++++++++++++++++
 tb/tb_img_pool_downsample.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pool_pkg.sv
// Shared types and helpers for the grayscale pooling downsampler.
package img_pool_pkg;

  typedef enum logic [1:0] {StClear, StAccum, StDrain} state_e;

  // Wide enough to sum 4^pool_shift full-scale 8-bit samples without overflow.
  function automatic int unsigned acc_width(input int unsigned pool_shift);
    return 8 + 2 * pool_shift;
  endfunction

  function automatic logic [31:0] header_word(input int unsigned w, input int unsigned h);
    return {w[15:0], h[15:0]};
  endfunction

endpackage

// File: rtl/pool_accum_ram.sv
// Accumulator storage: one write port, one registered read port returning the
// aligned group of four entries that contains the read address.
module pool_accum_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ACC_W  = 10,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [ACC_W-1:0]     wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [4*ACC_W-1:0]   rdata
);

  logic [ACC_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    for (int i = 0; i < 4; i++) begin
      rdata[ACC_W*i +: ACC_W] <= mem[(raddr & ~ADDR_W'(3)) | ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/img_pool_downsample.sv
// Pooling downsampler: accumulates decoded RGB pixels into grayscale cells, then
// streams a header word followed by packed pooled pixels.
module img_pool_downsample
  import img_pool_pkg::*;
#(
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned OUT_H      = 32,
  parameter int unsigned POOL_SHIFT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic [15:0] in_width,
  input  logic [15:0] in_height,
  output logic        upstream_stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        downstream_stall
);

  localparam int unsigned ACC_W  = acc_width(POOL_SHIFT);
  localparam int unsigned CELLS  = OUT_W * OUT_H;
  localparam int unsigned GROUPS = CELLS / 4;
  localparam int unsigned AW     = $clog2(CELLS);

  state_e            state_q;
  logic [AW-1:0]     clr_addr_q;
  logic [31:0]       count_q, total_q;
  logic              stall_q, eof_q;
  logic              p1_valid_q;
  logic [AW-1:0]     p1_addr_q;
  logic [7:0]        p1_gray_q;
  logic              fwd_we_q;
  logic [AW-1:0]     fwd_addr_q;
  logic [ACC_W-1:0]  fwd_data_q;
  logic [31:0]       rd_grp_q;
  logic              inflight_q, hdr_sent_q, skid_valid_q, out_valid_q;
  logic [31:0]       skid_data_q, out_data_q;

  logic              accept, in_win, last_pix, pop, issue, drain_done;
  logic [9:0]        gray_sum;
  logic [7:0]        gray;
  logic [15:0]       cell_x, cell_y;
  logic [AW-1:0]     in_addr;
  logic [31:0]       frame_total, count_next, rd_word;
  logic [2:0]        occ_after;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [ACC_W-1:0]  ram_wdata, rd_lane, acc_base, acc_sum;
  logic [4*ACC_W-1:0] ram_rdata;

  assign accept   = in_valid && !stall_q;
  assign gray_sum = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
  assign gray     = 8'(gray_sum >> 2);
  assign cell_x   = in_x >> POOL_SHIFT;
  assign cell_y   = in_y >> POOL_SHIFT;
  assign in_win   = ({16'd0, cell_x} < OUT_W) && ({16'd0, cell_y} < OUT_H);
  assign in_addr  = AW'(cell_y * OUT_W + cell_x);

  assign frame_total = (count_q == 32'd0) ? 32'(in_width) * 32'(in_height) : total_q;
  assign count_next  = count_q + 32'd1;
  assign last_pix    = (frame_total == 32'd0) || (count_next == frame_total);

  // The RAM returns pre-write data when a read collides with last cycle's write,
  // so the freshest sum for a back-to-back hit comes from the forward register.
  assign rd_lane  = ram_rdata[ACC_W * 32'(p1_addr_q[1:0]) +: ACC_W];
  assign acc_base = (fwd_we_q && fwd_addr_q == p1_addr_q) ? fwd_data_q : rd_lane;
  assign acc_sum  = acc_base + ACC_W'(p1_gray_q);

  assign ram_we    = (state_q == StClear) || p1_valid_q;
  assign ram_waddr = (state_q == StClear) ? clr_addr_q : p1_addr_q;
  assign ram_wdata = (state_q == StClear) ? '0 : acc_sum;
  assign ram_raddr = (state_q == StDrain) ? AW'(rd_grp_q << 2) : in_addr;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = 8'(ram_rdata[ACC_W*i +: ACC_W] >> (2 * POOL_SHIFT));
    end
  end

  // Reads are only issued when the output and skid registers can absorb them.
  assign pop        = out_valid_q && !downstream_stall;
  assign occ_after  = 3'(out_valid_q) + 3'(skid_valid_q) + 3'(inflight_q) + 3'(!hdr_sent_q)
                    - 3'(pop);
  assign issue      = (state_q == StDrain) && (occ_after < 3'd2) && (rd_grp_q < GROUPS);
  assign drain_done = hdr_sent_q && (rd_grp_q == GROUPS) && !inflight_q && !skid_valid_q && pop;

  pool_accum_ram #(
    .DEPTH  (CELLS),
    .ACC_W  (ACC_W),
    .ADDR_W (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StClear;
      clr_addr_q   <= '0;
      count_q      <= '0;
      total_q      <= '0;
      stall_q      <= 1'b1;
      eof_q        <= 1'b0;
      p1_valid_q   <= 1'b0;
      p1_addr_q    <= '0;
      p1_gray_q    <= '0;
      fwd_we_q     <= 1'b0;
      fwd_addr_q   <= '0;
      fwd_data_q   <= '0;
      rd_grp_q     <= '0;
      inflight_q   <= 1'b0;
      hdr_sent_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      fwd_we_q   <= p1_valid_q;
      fwd_addr_q <= p1_addr_q;
      fwd_data_q <= acc_sum;
      p1_valid_q <= accept && in_win;
      p1_addr_q  <= in_addr;
      p1_gray_q  <= gray;
      inflight_q <= issue;
      if (issue) begin
        rd_grp_q <= rd_grp_q + 32'd1;
      end
      unique case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == AW'(CELLS - 1)) begin
            clr_addr_q <= '0;
            stall_q    <= 1'b0;
            state_q    <= StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            total_q <= frame_total;
            count_q <= last_pix ? 32'd0 : count_next;
            if (last_pix) begin
              stall_q <= 1'b1;
              eof_q   <= 1'b1;
            end
          end
          // The end-of-frame pixel is being written this cycle.
          if (eof_q) begin
            eof_q      <= 1'b0;
            hdr_sent_q <= 1'b0;
            rd_grp_q   <= '0;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          if (!hdr_sent_q) begin
            out_data_q  <= header_word(OUT_W, OUT_H);
            out_valid_q <= 1'b1;
            hdr_sent_q  <= 1'b1;
          end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
              out_data_q   <= skid_data_q;
              out_valid_q  <= 1'b1;
              skid_valid_q <= inflight_q;
              if (inflight_q) begin
                skid_data_q <= rd_word;
              end
            end else if (inflight_q) begin
              out_data_q  <= rd_word;
              out_valid_q <= 1'b1;
            end else begin
              out_valid_q <= 1'b0;
            end
          end else if (inflight_q) begin
            skid_data_q  <= rd_word;
            skid_valid_q <= 1'b1;
          end
          if (drain_done) begin
            clr_addr_q <= '0;
            state_q    <= StClear;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign upstream_stall = stall_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

endmodule

// File: tb/tb_img_pool_downsample.sv
// Directed bench for img_pool_downsample with a 4x4 pooled grid and 2x2 windows.
module tb_img_pool_downsample;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_x, in_y, in_width, in_height;
  logic [7:0]  in_r, in_g, in_b;
  logic        upstream_stall, out_valid, downstream_stall;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int frame_waits = 0;
  logic [31:0] got [0:7];
  int ngot, first_cyc, last_cyc;

  always #5 clock = ~clock;

  img_pool_downsample #(
    .OUT_W      (4),
    .OUT_H      (4),
    .POOL_SHIFT (1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_x             (in_x),
    .in_y             (in_y),
    .in_r             (in_r),
    .in_g             (in_g),
    .in_b             (in_b),
    .in_width         (in_width),
    .in_height        (in_height),
    .upstream_stall   (upstream_stall),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .downstream_stall (downstream_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_px(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    int w = 0;
    in_valid = 1'b1;
    in_x = 16'(x);
    in_y = 16'(y);
    in_r = r;
    in_g = g;
    in_b = b;
    while (upstream_stall && w < 100) begin
      @(negedge clock);
      w++;
    end
    @(negedge clock);
    frame_waits += w;
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input int v, input int limit);
    int n = 0;
    in_width  = 16'(w);
    in_height = 16'(h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n < limit) begin
          case (mode)
            1: send_px(x, y, 8'd255, 8'd0, 8'd0);
            2: begin
              if (x < 8 && y < 8) send_px(x, y, 8'd200, 8'd200, 8'd200);
              else send_px(x, y, 8'd50, 8'd50, 8'd50);
            end
            default: send_px(x, y, 8'(v), 8'(v), 8'(v));
          endcase
          n++;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Counts stalled cycles from the current negedge until pixels are accepted again.
  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (upstream_stall && cnt < 200) begin
      cnt++;
      @(negedge clock);
    end
    check(tag, cnt, 16);
  endtask

  task automatic check_frame(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] e3, input int stall_after, input int stall_len);
    int cyc = 0;
    int stalled = 0;
    logic hold_chk = 1'b0;
    logic [31:0] held = '0;
    check("pixel_stalls", frame_waits, 0);
    frame_waits = 0;
    check("eof_stall", 32'(upstream_stall), 1);
    check("eof_ovalid", 32'(out_valid), 0);
    ngot = 0;
    first_cyc = -1;
    last_cyc = -1;
    while (ngot < 5 && cyc < 200) begin
      if (hold_chk) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", out_data, held);
      end
      downstream_stall = (ngot == stall_after && stalled < stall_len && out_valid);
      if (downstream_stall) stalled++;
      hold_chk = out_valid && downstream_stall;
      held = out_data;
      if (out_valid && !downstream_stall) begin
        if (ngot == 0) first_cyc = cyc;
        last_cyc = cyc;
        got[ngot] = out_data;
        ngot++;
      end
      @(negedge clock);
      cyc++;
    end
    downstream_stall = 1'b0;
    check("word_count", ngot, 5);
    check("tail_valid", 32'(out_valid), 0);
    check("header", got[0], 32'h0004_0004);
    check("word0", got[1], e0);
    check("word1", got[2], e1);
    check("word2", got[3], e2);
    check("word3", got[4], e3);
    if (stall_len == 0) begin
      check("hdr_latency", 32'(first_cyc <= 3), 1);
      check("burst_len", last_cyc - first_cyc, 4);
    end
    wait_ready("clear_after_drain");
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    in_width = 16'd8;
    in_height = 16'd8;
    downstream_stall = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_stall", 32'(upstream_stall), 1);
    check("rst_ovalid", 32'(out_valid), 0);
    check("rst_odata", out_data, 32'h0);
    wait_ready("clear_after_reset");

    // Uniform gray 100.
    run_frame(8, 8, 0, 100, 64);
    check_frame(32'h6464_6464, 32'h6464_6464, 32'h6464_6464, 32'h6464_6464, 99, 0);

    // Pure red: (255 + 0 + 0) >> 2 = 63.
    run_frame(8, 8, 1, 0, 64);
    check_frame(32'h3F3F_3F3F, 32'h3F3F_3F3F, 32'h3F3F_3F3F, 32'h3F3F_3F3F, 99, 0);

    // 16x16 source: only the top-left 8x8 lands in the grid.
    run_frame(16, 16, 2, 0, 256);
    check_frame(32'hC8C8_C8C8, 32'hC8C8_C8C8, 32'hC8C8_C8C8, 32'hC8C8_C8C8, 99, 0);

    // 7x7 source: right column and bottom row windows are partial (200>>2, 100>>2).
    run_frame(7, 7, 0, 100, 49);
    check_frame(32'h3264_6464, 32'h3264_6464, 32'h3264_6464, 32'h1932_3232, 99, 0);

    // Back-to-back hits on cell 0 (4+8+12+16)>>2 = 10; cell 1 gets (10+40+31)>>2 = 20 -> 5.
    in_width = 16'd8;
    in_height = 16'd8;
    send_px(0, 0, 8'd4, 8'd4, 8'd4);
    send_px(1, 0, 8'd8, 8'd8, 8'd8);
    send_px(0, 1, 8'd12, 8'd12, 8'd12);
    send_px(1, 1, 8'd16, 8'd16, 8'd16);
    send_px(2, 0, 8'd10, 8'd20, 8'd31);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (!((x < 2 && y < 2) || (x == 2 && y == 0))) send_px(x, y, 8'd0, 8'd0, 8'd0);
      end
    end
    in_valid = 1'b0;
    check_frame(32'h0000_050A, 32'h0, 32'h0, 32'h0, 2, 5);

    // Zero-area frame ends on its first pixel: gray 40 -> 10.
    run_frame(0, 8, 0, 0, 0);
    in_width = 16'd0;
    in_height = 16'd8;
    send_px(0, 0, 8'd40, 8'd40, 8'd40);
    in_valid = 1'b0;
    check_frame(32'h0000_000A, 32'h0, 32'h0, 32'h0, 99, 0);

    // Abandon a bright frame mid-accumulation, then a black frame must read all zero.
    run_frame(8, 8, 0, 255, 30);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("midrst_stall", 32'(upstream_stall), 1);
    check("midrst_ovalid", 32'(out_valid), 0);
    check("midrst_odata", out_data, 32'h0);
    frame_waits = 0;
    wait_ready("clear_after_midrst");
    run_frame(8, 8, 0, 0, 64);
    check_frame(32'h0, 32'h0, 32'h0, 32'h0, 99, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
